dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states between request acceptance and response; legal range 0..15.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  load result zero-extended when 1, sign-extended when 0.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  initiator consumes the response.
REQ-014 rsp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was rejected (misaligned, out of range, or illegal size).

Function
REQ-016 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE while reset is low; rsp_valid SHALL be 1 only in RESP.
REQ-018 Acceptance occurs at a rising edge with req_valid=1 and req_ready=1; the block SHALL latch we, addr, size, unsigned and wdata at that edge.
REQ-019 On acceptance, the FSM SHALL move to WAIT with the counter loaded to WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0.
REQ-020 In WAIT the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-021 rsp_valid SHALL therefore first assert exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1; the FSM then SHALL return to IDLE.
REQ-023 There is no back-to-back acceptance: req_ready SHALL be 0 in the RESP cycle in which rsp_ready is sampled.
REQ-024 An error SHALL be flagged when any of the following holds:
  - req_size = 11;
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] ≠ 00;
  - addr[31:2] ≥ DEPTH_WORDS.
REQ-025 On error: no memory write, rsp_err = 1, rsp_rdata = 0.
REQ-026 A legal store SHALL update memory at the edge entering RESP, writing only the addressed lanes:
  - byte: wdata[7:0] into lane addr[1:0];
  - halfword: wdata[15:0] into lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes.
REQ-027 A store response SHALL have rsp_rdata = 0 and rsp_err = 0.
REQ-028 A legal load SHALL read memory at the edge entering RESP.
REQ-029 Load data SHALL be extracted from the addressed lane(s) and extended to 32 bits per req_unsigned; req_unsigned SHALL be ignored for word loads.
REQ-030 Memory is little-endian: lane 0 = bits [7:0].
REQ-031 A store followed by a load to the same word SHALL return the stored data.
REQ-032 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-033 While reset is high: FSM = IDLE, counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-034 Reset asserted mid-transaction (WAIT or RESP) SHALL abandon the transaction; a store not yet committed SHALL NOT be written.
REQ-035 Memory contents SHALL NOT be cleared by reset; the memory is initialisable by $readmemh on the storage array.
REQ-036 req_ready SHALL rise combinationally on reset deassertion; the first acceptance is possible at the first rising edge after that.

Verification (WAIT_CYCLES=2)
REQ-037 Store word 0x0000_0019 to addr 0x64, then load word from 0x64 -> rsp_valid 3 cycles after each acceptance; load rsp_rdata = 0x0000_0019, rsp_err = 0.
REQ-038 Word 0x80FF_7F01 at 0x10; load byte signed from 0x13 -> 0xFFFF_FF80; load byte unsigned from 0x11 -> 0x0000_007F; load halfword signed from 0x12 -> 0xFFFF_80FF.
REQ-039 Store byte 0xAB to 0x21 over word 0x1122_3344 at 0x20, then load word 0x20 -> 0x1122_AB44.
REQ-040 Word load at 0x62 and load from 0x400 (DEPTH_WORDS=256) -> rsp_err = 1, rsp_rdata = 0; the memory word at 0x60 is unchanged.
REQ-041 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and data stable and req_ready = 0 throughout; completion at the first edge with rsp_ready = 1.
REQ-042 Assert reset one cycle after store acceptance to 0x40 -> all outputs 0 immediately; a subsequent load from 0x40 returns the pre-store value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder in front of a
// little-endian 32-bit word memory. A request is accepted in IDLE, held for
// WAIT_CYCLES wait states, then executed on the edge entering RESP. The
// response is held until the initiator consumes it.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request fields captured at acceptance
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  // Response registers, loaded on the edge entering RESP
  logic [31:0] rdata_q;
  logic        err_q;

  // Storage; left without reset so it can be preloaded externally
  logic [31:0] mem [0:DEPTH_WORDS-1];

  // Fields of the transaction being executed. With zero wait states the
  // request is executed on its own acceptance edge, so the live inputs are
  // used while still in IDLE.
  logic        x_we;
  logic [31:0] x_addr;
  logic [1:0]  x_size;
  logic        x_uns;
  logic [31:0] x_wdata;
  logic [29:0] x_widx;
  logic [1:0]  x_lane;
  logic        x_err;
  logic [31:0] x_word;
  logic        accept;
  logic        enter_resp;

  // Extract the addressed byte/halfword/word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Merge right-justified store data into the addressed lanes of a word.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;

  assign accept = req_valid && req_ready;

  assign x_we    = (state_q == S_IDLE) ? req_we       : we_q;
  assign x_addr  = (state_q == S_IDLE) ? req_addr     : addr_q;
  assign x_size  = (state_q == S_IDLE) ? req_size     : size_q;
  assign x_uns   = (state_q == S_IDLE) ? req_unsigned : uns_q;
  assign x_wdata = (state_q == S_IDLE) ? req_wdata    : wdata_q;
  assign x_widx  = x_addr[31:2];
  assign x_lane  = x_addr[1:0];

  assign x_err = (x_size == 2'b11)
              || ((x_size == 2'b01) && x_lane[0])
              || ((x_size == 2'b10) && (x_lane != 2'b00))
              || (x_widx >= 30'(DEPTH_WORDS));

  assign x_word = mem[x_widx[AW-1:0]];

  assign enter_resp = !reset && (state_q != S_RESP) && (state_d == S_RESP);

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request at acceptance; later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  // Execute the transaction's read side on the edge entering RESP
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      err_q   <= x_err;
      rdata_q <= (x_err || x_we) ? 32'h0 : load_extract(x_word, x_lane, x_size, x_uns);
    end
  end

  // Commit legal stores on the edge entering RESP
  always_ff @(posedge clk) begin
    if (enter_resp && x_we && !x_err) begin
      mem[x_widx[AW-1:0]] <= store_merge(x_word, x_wdata, x_lane, x_size);
    end
  end

endmodule
